// File: rtl/alu_arbiter_if.sv
// Bundles the requester, result and ALU-side character streams of alu_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface alu_arbiter_if;
  logic [1:0]  req_stb;
  logic [15:0] req_char;
  logic [1:0]  req_ack;
  logic [1:0]  rsp_stb;
  logic [7:0]  rsp_char;
  logic [1:0]  rsp_ack;
  logic        alu_in_stb;
  logic [7:0]  alu_in_char;
  logic        alu_in_ack;
  logic        alu_out_stb;
  logic [7:0]  alu_out_char;
  logic        alu_out_ack;
  logic        alu_rst;
  logic        grant;
  logic        busy;

  modport slave (
    input  req_stb, req_char, rsp_ack, alu_in_ack, alu_out_stb, alu_out_char,
    output req_ack, rsp_stb, rsp_char, alu_in_stb, alu_in_char, alu_out_ack,
           alu_rst, grant, busy
  );

  modport master (
    output req_stb, req_char, rsp_ack, alu_in_ack, alu_out_stb, alu_out_char,
    input  req_ack, rsp_stb, rsp_char, alu_in_stb, alu_in_char, alu_out_ack,
           alu_rst, grant, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one RPN ALU between two character-stream requesters. A requester owns
// the ALU from its first character through '=' until the ALU's LF terminator;
// a stalled expression is aborted after TIMEOUT idle cycles and the ALU cleared.
module alu_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FWD, RESULT, ABORT} state_t;

  state_t        state;
  logic          grant_q;
  logic          last_q;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] idle_next;
  logic [7:0]    sel_char;
  logic          in_xfer;
  logic          out_xfer;
  logic          pick;

  assign sel_char  = grant_q ? bus.req_char[15:8] : bus.req_char[7:0];
  assign in_xfer   = (state == FWD) && bus.req_stb[grant_q] && bus.alu_in_ack;
  assign out_xfer  = (state == RESULT) && bus.alu_out_stb && bus.rsp_ack[grant_q];
  assign pick      = (&bus.req_stb) ? ~last_q : bus.req_stb[1];
  assign idle_next = idle_cnt + CW'(1);

  assign bus.alu_rst = (state == ABORT);
  assign bus.busy    = (state == FWD) || (state == RESULT);
  assign bus.grant   = grant_q;

  // Route the owner's streams straight through; everything else is held quiet.
  always_comb begin
    bus.req_ack     = 2'b00;
    bus.rsp_stb     = 2'b00;
    bus.rsp_char    = 8'h00;
    bus.alu_in_stb  = 1'b0;
    bus.alu_in_char = 8'h00;
    bus.alu_out_ack = 1'b0;
    case (state)
      FWD: begin
        bus.alu_in_stb       = bus.req_stb[grant_q];
        bus.alu_in_char      = sel_char;
        bus.req_ack[grant_q] = bus.alu_in_ack;
      end
      RESULT: begin
        bus.rsp_stb[grant_q] = bus.alu_out_stb;
        bus.rsp_char         = bus.alu_out_char;
        bus.alu_out_ack      = bus.rsp_ack[grant_q];
      end
      default: ;
    endcase
  end

  // Ownership FSM: round-robin grant, expression framing and stall timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (|bus.req_stb) begin
            grant_q <= pick;
            state   <= FWD;
          end
        end
        FWD: begin
          if (in_xfer) begin
            idle_cnt <= '0;
            if (sel_char == 8'h3D) state <= RESULT;
          end else begin
            idle_cnt <= idle_next;
            if (idle_next == CW'(TIMEOUT)) state <= ABORT;
          end
        end
        RESULT: begin
          if (out_xfer) begin
            idle_cnt <= '0;
            if (bus.alu_out_char == 8'h0A) begin
              last_q <= grant_q;
              state  <= IDLE;
            end
          end else begin
            idle_cnt <= idle_next;
            if (idle_next == CW'(TIMEOUT)) state <= ABORT;
          end
        end
        ABORT: begin
          idle_cnt <= '0;
          last_q   <= grant_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the bench plays both requesters and the ALU,
// drives inputs just after each rising edge and checks outputs mid-cycle.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_arbiter_if bus ();

  alu_arbiter #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] stb, input logic [15:0] chars);
    bus.req_stb  = stb;
    bus.req_char = chars;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ack"},     16'(bus.req_ack),     16'd0);
    checkOutput({tag, "_rsp_stb"},     16'(bus.rsp_stb),     16'd0);
    checkOutput({tag, "_alu_in_stb"},  16'(bus.alu_in_stb),  16'd0);
    checkOutput({tag, "_alu_out_ack"}, 16'(bus.alu_out_ack), 16'd0);
    checkOutput({tag, "_alu_rst"},     16'(bus.alu_rst),     16'd0);
    checkOutput({tag, "_busy"},        16'(bus.busy),        16'd0);
    checkOutput({tag, "_grant"},       16'(bus.grant),       16'd0);
    checkOutput({tag, "_alu_in_char"}, 16'(bus.alu_in_char), 16'd0);
    checkOutput({tag, "_rsp_char"},    16'(bus.rsp_char),    16'd0);
  endtask

  // One IDLE cycle with requests pending; the grant lands on the next edge.
  task automatic grantCycle(input string tag);
    #4;
    checkOutput({tag, "_idle_busy"}, 16'(bus.busy),    16'd0);
    checkOutput({tag, "_idle_ack"},  16'(bus.req_ack), 16'd0);
    checkOutput({tag, "_idle_rst"},  16'(bus.alu_rst), 16'd0);
    tick();
  endtask

  task automatic fwdChar(input logic idx, input logic [7:0] ch, input string tag);
    logic [1:0] exp_ack;
    exp_ack = idx ? 2'b10 : 2'b01;
    bus.req_stb[idx] = 1'b1;
    if (idx) bus.req_char[15:8] = ch;
    else     bus.req_char[7:0]  = ch;
    bus.alu_in_ack = 1'b1;
    #4;
    checkOutput({tag, "_busy"},    16'(bus.busy),        16'd1);
    checkOutput({tag, "_grant"},   16'(bus.grant),       16'(idx));
    checkOutput({tag, "_in_stb"},  16'(bus.alu_in_stb),  16'd1);
    checkOutput({tag, "_in_char"}, 16'(bus.alu_in_char), 16'(ch));
    checkOutput({tag, "_req_ack"}, 16'(bus.req_ack),     16'(exp_ack));
    checkOutput({tag, "_out_ack"}, 16'(bus.alu_out_ack), 16'd0);
    checkOutput({tag, "_rsp_stb"}, 16'(bus.rsp_stb),     16'd0);
    tick();
    bus.req_stb[idx] = 1'b0;
    bus.alu_in_ack   = 1'b0;
  endtask

  task automatic resChar(input logic idx, input logic [7:0] ch, input string tag);
    logic [1:0] exp_stb;
    exp_stb = idx ? 2'b10 : 2'b01;
    bus.alu_out_stb  = 1'b1;
    bus.alu_out_char = ch;
    bus.rsp_ack      = exp_stb;
    #4;
    checkOutput({tag, "_busy"},     16'(bus.busy),        16'd1);
    checkOutput({tag, "_rsp_stb"},  16'(bus.rsp_stb),     16'(exp_stb));
    checkOutput({tag, "_rsp_char"}, 16'(bus.rsp_char),    16'(ch));
    checkOutput({tag, "_out_ack"},  16'(bus.alu_out_ack), 16'd1);
    checkOutput({tag, "_req_ack"},  16'(bus.req_ack),     16'd0);
    checkOutput({tag, "_in_stb"},   16'(bus.alu_in_stb),  16'd0);
    tick();
    bus.alu_out_stb = 1'b0;
    bus.rsp_ack     = 2'b00;
  endtask

  // Directed scenarios: single owner, tie/round-robin with stall, backpressure,
  // timeout abort, and asynchronous reset in the middle of an expression.
  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    bus.req_stb      = 2'b00;
    bus.req_char     = 16'h0000;
    bus.rsp_ack      = 2'b00;
    bus.alu_in_ack   = 1'b0;
    bus.alu_out_stb  = 1'b0;
    bus.alu_out_char = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;

    $display("[TB] single owner");
    applyStimulus(2'b01, 16'h0032);
    grantCycle("t1_grant");
    fwdChar(1'b0, 8'h32, "t1_c0");
    fwdChar(1'b0, 8'h31, "t1_c1");
    fwdChar(1'b0, 8'h2B, "t1_c2");
    fwdChar(1'b0, 8'h3D, "t1_c3");
    resChar(1'b0, 8'h33, "t1_r0");
    resChar(1'b0, 8'h0A, "t1_r1");
    #4;
    checkOutput("t1_done_busy", 16'(bus.busy), 16'd0);
    tick();

    $display("[TB] tie and stall");
    doReset();
    applyStimulus(2'b11, 16'h3532);
    grantCycle("t2_grant0");
    fwdChar(1'b0, 8'h32, "t2_a0");
    fwdChar(1'b0, 8'h3D, "t2_a1");
    resChar(1'b0, 8'h32, "t2_ar0");
    resChar(1'b0, 8'h0A, "t2_ar1");
    bus.req_stb[0]     = 1'b1;
    bus.req_char[7:0]  = 8'h39;
    grantCycle("t2_grant1");
    checkOutput("t2_stall_char", 16'(bus.req_char[15:8]), 16'h0035);
    fwdChar(1'b1, 8'h35, "t2_b0");
    fwdChar(1'b1, 8'h3D, "t2_b1");
    resChar(1'b1, 8'h35, "t2_br0");
    resChar(1'b1, 8'h0A, "t2_br1");
    bus.req_stb[1] = 1'b1;
    grantCycle("t2_grant2");
    fwdChar(1'b0, 8'h39, "t2_c0");
    bus.req_stb[1] = 1'b0;

    $display("[TB] backpressure");
    fwdChar(1'b0, 8'h3D, "t3_c1");
    bus.alu_out_stb  = 1'b1;
    bus.alu_out_char = 8'h37;
    bus.rsp_ack      = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #4;
      checkOutput("t3_hold_stb",  16'(bus.rsp_stb),     16'd1);
      checkOutput("t3_hold_char", 16'(bus.rsp_char),    16'h0037);
      checkOutput("t3_hold_ack",  16'(bus.alu_out_ack), 16'd0);
      tick();
    end
    resChar(1'b0, 8'h37, "t3_r0");
    resChar(1'b0, 8'h0A, "t3_r1");

    $display("[TB] timeout");
    doReset();
    applyStimulus(2'b11, 16'h3532);
    grantCycle("t4_grant0");
    fwdChar(1'b0, 8'h32, "t4_c0");
    for (int i = 0; i < 16; i++) begin
      #4;
      checkOutput("t4_wait_busy", 16'(bus.busy),    16'd1);
      checkOutput("t4_wait_rst",  16'(bus.alu_rst), 16'd0);
      checkOutput("t4_wait_ack",  16'(bus.req_ack), 16'd0);
      tick();
    end
    #4;
    checkOutput("t4_abort_rst",  16'(bus.alu_rst),    16'd1);
    checkOutput("t4_abort_busy", 16'(bus.busy),       16'd0);
    checkOutput("t4_abort_ack",  16'(bus.req_ack),    16'd0);
    checkOutput("t4_abort_stb",  16'(bus.alu_in_stb), 16'd0);
    tick();
    grantCycle("t4_grant1");
    fwdChar(1'b1, 8'h35, "t4_b0");
    fwdChar(1'b1, 8'h3D, "t4_b1");
    resChar(1'b1, 8'h0A, "t4_br0");

    $display("[TB] reset mid-expression");
    applyStimulus(2'b01, 16'h0031);
    grantCycle("t5_grant0");
    bus.alu_in_ack = 1'b1;
    #4;
    checkOutput("t5_pre_stb", 16'(bus.alu_in_stb), 16'd1);
    reset = 1'b1;
    #1;
    checkResetValues("t5_async");
    tick();
    reset          = 1'b0;
    bus.alu_in_ack = 1'b0;
    grantCycle("t5_grant1");
    fwdChar(1'b0, 8'h31, "t5_c0");
    fwdChar(1'b0, 8'h3D, "t5_c1");
    resChar(1'b0, 8'h31, "t5_r0");
    resChar(1'b0, 8'h0A, "t5_r1");
    #4;
    checkOutput("t5_done_busy", 16'(bus.busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
